// File: rtl/global_sched_pkg.sv
// Definitions shared by the global scheduler's selector, its wrapper and the result FIFO.
package global_sched_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNTW_DEF  = 16;

    // Address bits plus one wrap bit, so full and empty can be told apart.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sched_fifo_mem.sv
// Simple dual-port register array: synchronous write port, asynchronous read port.
module sched_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sched_result_fifo.sv
// Result buffer behind the scheduler's valid-data selector: circular buffer, registered
// show-ahead output stage, overflow detection with sticky flag and saturating drop counter.
module sched_result_fifo
    import global_sched_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int CNTW      = CNTW_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       wr_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH+2)-1:0] level,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       overflow,
    output logic [CNTW-1:0]            drop_cnt,
    input  logic                       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam int LW = $clog2(DEPTH + 2);
    localparam logic [LW-1:0] AF_L = LW'(AF_THRESH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             overflow_q, overflow_d;
    logic [CNTW-1:0]  drop_cnt_q, drop_cnt_d;

    logic [PW-1:0]    mem_count;
    logic             mem_full, mem_empty;
    logic             wr_accept, wr_drop, load;
    logic [WIDTH-1:0] mem_rdata;

    assign mem_count = wr_ptr_q - rd_ptr_q;
    assign mem_empty = (wr_ptr_q == rd_ptr_q);
    assign mem_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                       (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);

    // The writer has no backpressure: a write while full is lost, even if a pop frees a slot.
    assign wr_accept = wr_en && !mem_full;
    assign wr_drop   = wr_en && mem_full;

    // A word transfers on any edge where rd_valid && rd_ready; rd_data and rd_valid
    // are held unchanged while rd_valid && !rd_ready.
    assign load = !mem_empty && (!rd_valid_q || rd_ready);

    sched_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        if (load) begin
            rd_data_d  = mem_rdata;
            rd_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + PW'(1);
        end else if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end

        // A drop in the same cycle as a clear is counted against the cleared value.
        if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
        if (wr_drop) begin
            overflow_d = 1'b1;
            if (clr_ovf) begin
                drop_cnt_d = CNTW'(1);
            end else if (drop_cnt_q != {CNTW{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign level       = LW'(mem_count) + LW'(rd_valid_q);
    assign empty       = (level == '0);
    assign full        = mem_full;
    assign almost_full = (level >= AF_L);
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;

endmodule
